fifo_stream_drain: RTL

- Downstream consumer of the synchronous FIFO. Drives the FIFO's read enable and captures its registered read data.
- Presents the data as a valid/ready stream with burst framing (m_last).
- A 3-entry internal skid buffer absorbs the FIFO's 1-cycle read latency. This sustains 1 word/cycle under continuous m_ready.
- fifo_r_enb never depends combinationally on m_ready.

---
 rtl/fifo_stream_drain_if.sv | 25 ++
 rtl/fifo_stream_drain.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain_if.sv
// Signal bundle between the FIFO read port, the drain controls and the valid/ready stream sink.
// The master modport is the drain's view; slave is the environment's view.
interface fifo_stream_drain_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] fifo_d_out;
  logic             fifo_empty;
  logic             fifo_r_enb;
  logic             en;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             idle;

  modport master (
    input  fifo_d_out, fifo_empty, en, m_ready,
    output fifo_r_enb, m_data, m_valid, m_last, idle
  );

  modport slave (
    output fifo_d_out, fifo_empty, en, m_ready,
    input  fifo_r_enb, m_data, m_valid, m_last, idle
  );
endinterface

// File: rtl/fifo_stream_drain.sv
// FIFO read-side drain: issues reads, absorbs the 1-cycle read latency in a 3-entry skid
// buffer and presents the words as a valid/ready stream with burst framing on m_last.
module fifo_stream_drain #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_drain_if.master  bus
);

  localparam int          DEPTH     = 3;
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [WIDTH-1:0] buf_d [DEPTH];
  logic [1:0]       rd_q, rd_d;
  logic [1:0]       wr_q, wr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;

  logic             r_enb_s;
  logic             valid_s;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;

  // Read issue: only reads that still fit (buffered + in flight < 3); never looks at m_ready.
  always_comb begin
    r_enb_s = 1'b0;
    if (!reset && bus.en && !bus.fifo_empty &&
        (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3)) begin
      r_enb_s = 1'b1;
    end else begin
      r_enb_s = 1'b0;
    end
  end

  // Next-state: capture the in-flight word at the tail, pop the head on handshake.
  always_comb begin
    valid_s    = (occ_q != 2'd0);
    pop_s      = valid_s && bus.m_ready;
    push_s     = inflight_q;
    inflight_d = r_enb_s;

    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_q == 2'(i))) begin
        buf_d[i] = bus.fifo_d_out;
      end else begin
        buf_d[i] = buf_q[i];
      end
    end

    if (push_s) begin
      wr_d = idx_next(wr_q);
    end else begin
      wr_d = wr_q;
    end

    if (pop_s) begin
      rd_d = idx_next(rd_q);
    end else begin
      rd_d = rd_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (pop_s) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = 16'd0;
      end else begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Head-of-buffer mux for the stream data.
  always_comb begin
    case (rd_q)
      2'd0:    head_s = buf_q[0];
      2'd1:    head_s = buf_q[1];
      2'd2:    head_s = buf_q[2];
      default: head_s = {WIDTH{1'b0}};
    endcase
  end

  // State registers; reset also zeroes the storage so m_data reads 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= {WIDTH{1'b0}};
      end
      rd_q       <= 2'd0;
      wr_q       <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.fifo_r_enb = r_enb_s;
  assign bus.m_valid    = valid_s;
  assign bus.m_data     = head_s;
  assign bus.m_last     = valid_s && (beat_cnt_q == LAST_BEAT);
  assign bus.idle       = (occ_q == 2'd0) && !inflight_q;

endmodule
